// File: rtl/adder_seq_ctrl_pkg.sv
// Shared constants and types for the nibble-serial adder sequencer.
package adder_seq_ctrl_pkg;

    // Width of the time-shared carry-lookahead slice.
    localparam int SLICE_W = 4;

    // FSM encoding, kept as plain 2-bit constants for compatibility with
    // existing decode logic elsewhere in the datapath.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Result flags reported alongside the sum.
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Operand B as seen by the slice: inverted for subtraction so that
    // A - B = A + ~B + 1, with the +1 supplied as the initial carry.
    function automatic logic [SLICE_W-1:0] eff_nibble(input logic [SLICE_W-1:0] nib,
                                                      input logic              inv);
        eff_nibble = inv ? ~nib : nib;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Request/result handshake bundle for adder_seq_ctrl.
interface adder_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Requester/consumer side.
    modport master (
        output in_valid, a, b, sub, flush, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a, b, sub, flush, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/adder_seq_ctrl_adder4.sv
// Existing 4-bit carry-lookahead slice. Exposes C3 (carry into bit 3)
// so the caller can derive signed overflow on the top slice.
module Adder4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic       c1_s;
    logic       c2_s;

    assign g_s = x & y;
    assign p_s = x ^ y;

    // Flattened lookahead equations; no ripple between bit positions.
    assign c1_s = g_s[0] | (p_s[0] & cin);
    assign c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c3   = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c4   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign s = p_s ^ {c3, c2_s, c1_s, cin};
endmodule

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit CLA slice is reused for
// WIDTH/4 cycles, least-significant nibble first, with valid/ready on both
// the request and the result side.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_seq_ctrl_if.slave         bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = $clog2(NSLICE);
    localparam int RES_W  = WIDTH - SLICE_W;

    state_t             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [RES_W-1:0]   res_r;
    logic [WIDTH-1:0]   sum_r;
    flags_t             flags_r;

    logic [SLICE_W-1:0] slice_sum_s;
    logic               c3_s;
    logic               c4_s;
    logic [WIDTH-1:0]   final_s;
    logic [RES_W-1:0]   res_shift_s;
    logic               last_s;
    logic               accept_s;

    // Single shared slice; operands are always the low nibble of the
    // right-shifting operand registers, i.e. nibble k in cycle k.
    Adder4 u_slice (
        .x   (a_r[SLICE_W-1:0]),
        .y   (b_r[SLICE_W-1:0]),
        .cin (carry_r),
        .s   (slice_sum_s),
        .c3  (c3_s),
        .c4  (c4_s)
    );

    // The result register holds the nibbles already produced; the newest
    // nibble enters at the top so that after the last slice the value is
    // already in place.
    generate
        if (RES_W > SLICE_W) begin : g_res_shift
            assign res_shift_s = {slice_sum_s, res_r[RES_W-1:SLICE_W]};
        end else begin : g_res_single
            assign res_shift_s = slice_sum_s;
        end
    endgenerate

    assign final_s  = {slice_sum_s, res_r};
    assign last_s   = (cnt_r == CNT_W'(NSLICE - 1));
    assign accept_s = bus.in_valid & in_ready_r;

    // Sequencer state, operand capture, nibble stepping and result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            res_r       <= {RES_W{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            flags_r     <= '{cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        end else if (bus.flush) begin
            // Cancel wins over both handshakes; reported results are kept.
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r        <= bus.a;
                        for (int i = 0; i < NSLICE; i++) begin
                            b_r[i*SLICE_W +: SLICE_W] <=
                                eff_nibble(bus.b[i*SLICE_W +: SLICE_W], bus.sub);
                        end
                        carry_r    <= bus.sub;
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_r     <= {{SLICE_W{1'b0}}, a_r[WIDTH-1:SLICE_W]};
                    b_r     <= {{SLICE_W{1'b0}}, b_r[WIDTH-1:SLICE_W]};
                    res_r   <= res_shift_s;
                    carry_r <= c4_s;
                    if (last_s) begin
                        cnt_r        <= {CNT_W{1'b0}};
                        sum_r        <= final_s;
                        flags_r.cout <= c4_s;
                        flags_r.ovf  <= c4_s ^ c3_s;
                        flags_r.zero <= (final_s == {WIDTH{1'b0}});
                        state_r      <= ST_DONE;
                        out_valid_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = flags_r.cout;
    assign bus.ovf       = flags_r.ovf;
    assign bus.zero      = flags_r.zero;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed, table-driven bench for adder_seq_ctrl (WIDTH=32).
module tb_adder_seq_ctrl;
    logic clk = 1'b0;
    logic rst;

    adder_seq_ctrl_if #(.WIDTH(32)) bus ();

    adder_seq_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues one request and waits for the result. lat counts rising edges
    // from the accepting edge (inclusive) up to the edge that raises out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] sum, output logic cout, output logic ovf,
                          output logic zero, output int lat, output bit got);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.sub = ~sub;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (bus.out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        sum = bus.sum; cout = bus.cout; ovf = bus.ovf; zero = bus.zero;
        if (!got) chk("out_valid_timeout", 64'd0, 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] r_sum;
    logic        r_cout, r_ovf, r_zero;
    int          r_lat;
    bit          r_got;
    int          bad;

    initial begin
        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0};

        bus.in_valid = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.sub = 1'b0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_in_ready",  bus.in_ready,  1'b1);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_sum",       bus.sum,       32'd0);
        chk("reset_flags",     {bus.cout, bus.ovf, bus.zero}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        // Main function over the vector table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r_sum, r_cout, r_ovf, r_zero, r_lat, r_got);
            chk($sformatf("v%0d_sum", i),  r_sum,  vecs[i].sum);
            chk($sformatf("v%0d_cout", i), r_cout, vecs[i].cout);
            chk($sformatf("v%0d_ovf", i),  r_ovf,  vecs[i].ovf);
            chk($sformatf("v%0d_zero", i), r_zero, vecs[i].zero);
            chk($sformatf("v%0d_latency", i), r_lat, 9);
            chk($sformatf("v%0d_ready_after", i), {bus.in_ready, bus.out_valid}, 2'b10);
        end

        // Backpressure: DONE held with out_ready low while inputs wiggle.
        @(negedge clk);
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        r_lat = 0;
        while (!bus.out_valid && r_lat < 40) begin
            @(posedge clk); @(negedge clk); r_lat++;
        end
        chk("bp_reached_done", bus.out_valid, 1'b1);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            bus.a = $urandom; bus.b = $urandom; bus.sub = c[0]; bus.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (bus.sum !== 32'h2345_6789 || {bus.cout, bus.ovf, bus.zero} !== 3'b000 ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);

        // Flush in RUN cycle 3 together with a new request.
        bus.a = 32'h0000_0001; bus.b = 32'hFFFF_FFFF; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.a = 32'hAAAA_AAAA; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("flush_idle_next", {bus.in_ready, bus.out_valid}, 2'b10);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        chk("flush_no_result", bad, 0);
        chk("flush_sum_kept",   bus.sum, 32'h2345_6789);
        chk("flush_flags_kept", {bus.cout, bus.ovf, bus.zero}, 3'b000);

        // Asynchronous reset between clock edges in the middle of RUN.
        bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0003; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready",  bus.in_ready,  1'b1);
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_sum",       bus.sum,       32'd0);
        chk("arst_flags",     {bus.cout, bus.ovf, bus.zero}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, r_sum, r_cout, r_ovf, r_zero, r_lat, r_got);
        chk("arst_after_sum",   r_sum, 32'h2345_6789);
        chk("arst_after_flags", {r_cout, r_ovf, r_zero}, 3'b000);
        chk("arst_after_lat",   r_lat, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
